// File: rtl/mem_dump_pkg.sv
// Shared constants, state encoding and halt decode for the post-halt memory dump unit.
package mem_dump_pkg;

   // Default word and address widths of the 16-bit core
   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;

   // The two instruction encodings the core uses to halt
   localparam logic [DATA_W-1:0] HALT_A = 16'hE000;
   localparam logic [DATA_W-1:0] HALT_B = 16'hE7FF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_DRAIN = 3'd1,
      ST_READ  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_EMIT  = 3'd4,
      ST_DONE  = 3'd5
   } dump_state_t;

   // True when the instruction is either halt encoding
   function automatic logic is_halt(input logic [DATA_W-1:0] instr);
      return (instr == HALT_A) || (instr == HALT_B);
   endfunction

endpackage

// File: rtl/mem_dump_unit_halt_detector.sv
// Halt detector: recognises either halt encoding and fires exactly once per reset.
// The armed flag stops a halt instruction that sits in decode for several cycles
// from producing more than one pulse.
module halt_detector #(
   parameter int DATA_W = mem_dump_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] instr_i,
   output logic              halt_o
);
   import mem_dump_pkg::*;

   logic w_hit;
   logic r_armed;

   assign w_hit  = is_halt(instr_i);
   assign halt_o = w_hit & r_armed;

   // Disarm after the first recognised halt; only reset re-arms
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_armed <= 1'b1;
      end else if (w_hit) begin
         r_armed <= 1'b0;
      end else begin
         r_armed <= r_armed;
      end
   end

endmodule

// File: rtl/mem_dump_unit.sv
// Post-halt memory dump: waits for the pipeline to drain after a halt, scans the
// data-memory window through a one-cycle-latency read port and streams each
// (nonzero) word with its address over a valid/ready interface.
module mem_dump_unit #(
   parameter int DATA_W       = mem_dump_pkg::DATA_W,
   parameter int ADDR_W       = mem_dump_pkg::ADDR_W,
   parameter int BASE_ADDR    = 0,
   parameter int DEPTH        = 65536,
   parameter int DRAIN_CYCLES = 10,
   parameter int SKIP_ZERO    = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] instr_i,
   output logic              mem_rd_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rd_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [ADDR_W-1:0] out_addr_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W:0]   word_count_o
);
   import mem_dump_pkg::*;

   // Drain counter only needs to hold DRAIN_CYCLES
   localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0] L_DRAIN_INIT = CNT_W'(DRAIN_CYCLES);
   localparam logic [CNT_W-1:0] L_CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] L_CNT_ZERO   = CNT_W'(0);

   // Pointer is one bit wider than the address so a full 2^ADDR_W scan ends on
   // the last word instead of wrapping back to zero.
   localparam int               L_LAST_I   = BASE_ADDR + DEPTH - 1;
   localparam logic [ADDR_W:0]  L_BASE_PTR = (ADDR_W+1)'(BASE_ADDR);
   localparam logic [ADDR_W:0]  L_LAST_PTR = (ADDR_W+1)'(L_LAST_I);
   localparam logic [ADDR_W:0]  L_PTR_ONE  = (ADDR_W+1)'(1);
   localparam logic             L_KEEP_ALL = (SKIP_ZERO == 0);

   logic                w_halt;
   dump_state_t         r_state;
   dump_state_t         w_state_nxt;
   logic [CNT_W-1:0]    r_drain;
   logic [CNT_W-1:0]    w_drain_nxt;
   logic [ADDR_W:0]     r_ptr;
   logic [ADDR_W:0]     w_ptr_nxt;
   logic                w_adv;
   logic                w_capture;
   logic                w_accept;

   logic                r_rd_en;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_valid;
   logic [ADDR_W-1:0]   r_oaddr;
   logic [DATA_W-1:0]   r_odata;
   logic                r_busy;
   logic                r_done;
   logic [ADDR_W:0]     r_count;

   halt_detector #(
      .DATA_W (DATA_W)
   ) u_halt_detector (
      .clk     (clk),
      .reset_n (reset_n),
      .instr_i (instr_i),
      .halt_o  (w_halt)
   );

   assign w_capture = (r_state == ST_WAIT) && (w_state_nxt == ST_EMIT);
   assign w_accept  = (r_state == ST_EMIT) && out_ready_i;

   // Next-state, drain counter and scan pointer decisions
   always_comb begin
      w_state_nxt = r_state;
      w_drain_nxt = r_drain;
      w_ptr_nxt   = r_ptr;
      w_adv       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_halt) begin
               w_drain_nxt = L_DRAIN_INIT;
               w_ptr_nxt   = L_BASE_PTR;
               w_state_nxt = (DRAIN_CYCLES == 0) ? ST_READ : ST_DRAIN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            // Leaving on the count of one gives exactly DRAIN_CYCLES drain cycles
            if (r_drain <= L_CNT_ONE) begin
               w_drain_nxt = L_CNT_ZERO;
               w_state_nxt = ST_READ;
            end else begin
               w_drain_nxt = r_drain - L_CNT_ONE;
            end
         end
         ST_READ: begin
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if ((mem_rd_data_i != '0) || L_KEEP_ALL) begin
               w_state_nxt = ST_EMIT;
            end else begin
               w_adv = 1'b1;
            end
         end
         ST_EMIT: begin
            if (out_ready_i) begin
               w_adv = 1'b1;
            end else begin
               w_state_nxt = ST_EMIT;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_DONE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (w_adv) begin
         if (r_ptr == L_LAST_PTR) begin
            w_state_nxt = ST_DONE;
         end else begin
            w_ptr_nxt   = r_ptr + L_PTR_ONE;
            w_state_nxt = ST_READ;
         end
      end else begin
         w_ptr_nxt = w_ptr_nxt;
      end
   end

   // FSM state, drain counter and scan pointer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_drain <= L_CNT_ZERO;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_drain <= w_drain_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   // Memory read strobe and address, registered from the state being entered
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_en <= 1'b0;
         r_addr  <= '0;
      end else begin
         r_rd_en <= (w_state_nxt == ST_READ);
         if (w_state_nxt == ST_READ) begin
            r_addr <= w_ptr_nxt[ADDR_W-1:0];
         end else begin
            r_addr <= r_addr;
         end
      end
   end

   // Output word: captured at the end of WAIT and held until the handshake
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_oaddr <= '0;
         r_odata <= '0;
      end else begin
         r_valid <= (w_state_nxt == ST_EMIT);
         if (w_capture) begin
            r_oaddr <= r_ptr[ADDR_W-1:0];
            r_odata <= mem_rd_data_i;
         end else begin
            r_oaddr <= r_oaddr;
            r_odata <= r_odata;
         end
      end
   end

   // Status flags and accepted-word counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_count <= '0;
      end else begin
         r_busy <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
         r_done <= (w_state_nxt == ST_DONE);
         if (w_accept) begin
            r_count <= r_count + L_PTR_ONE;
         end else begin
            r_count <= r_count;
         end
      end
   end

   assign mem_rd_en_o  = r_rd_en;
   assign mem_addr_o   = r_addr;
   assign out_valid_o  = r_valid;
   assign out_addr_o   = r_oaddr;
   assign out_data_o   = r_odata;
   assign busy_o       = r_busy;
   assign done_o       = r_done;
   assign word_count_o = r_count;

endmodule

// File: tb/tb_mem_dump_unit.sv
// Directed bench for mem_dump_unit: three instances cover the skip-zero dump with
// and without backpressure, the keep-all mode with zero drain, and a full-range
// scan on a narrow address bus (the no-wrap boundary).
module tb_mem_dump_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   logic ready;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Instance A: DEPTH 8, drain 2, skip zeros
   logic [15:0] instr_a, rdata_a, odata_a;
   logic [15:0] addr_a, oaddr_a;
   logic        rd_en_a, valid_a, busy_a, done_a;
   logic [16:0] cnt_a;
   logic [15:0] mem_a [0:7];

   // Instance B: DEPTH 4, no drain, keep zeros
   logic [15:0] instr_b, rdata_b, odata_b;
   logic [15:0] addr_b, oaddr_b;
   logic        rd_en_b, valid_b, busy_b, done_b;
   logic [16:0] cnt_b;
   logic [15:0] mem_b [0:3];

   // Instance C: 8-bit address, full 256-word range, drain 1
   logic [15:0] instr_c, rdata_c, odata_c;
   logic [7:0]  addr_c, oaddr_c;
   logic        rd_en_c, valid_c, busy_c, done_c;
   logic [8:0]  cnt_c;
   logic [15:0] mem_c [0:255];

   mem_dump_unit #(.DATA_W(16), .ADDR_W(16), .BASE_ADDR(0), .DEPTH(8),
                   .DRAIN_CYCLES(2), .SKIP_ZERO(1)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .instr_i(instr_a),
      .mem_rd_en_o(rd_en_a), .mem_addr_o(addr_a), .mem_rd_data_i(rdata_a),
      .out_valid_o(valid_a), .out_ready_i(ready), .out_addr_o(oaddr_a),
      .out_data_o(odata_a), .busy_o(busy_a), .done_o(done_a), .word_count_o(cnt_a));

   mem_dump_unit #(.DATA_W(16), .ADDR_W(16), .BASE_ADDR(0), .DEPTH(4),
                   .DRAIN_CYCLES(0), .SKIP_ZERO(0)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .instr_i(instr_b),
      .mem_rd_en_o(rd_en_b), .mem_addr_o(addr_b), .mem_rd_data_i(rdata_b),
      .out_valid_o(valid_b), .out_ready_i(ready), .out_addr_o(oaddr_b),
      .out_data_o(odata_b), .busy_o(busy_b), .done_o(done_b), .word_count_o(cnt_b));

   mem_dump_unit #(.DATA_W(16), .ADDR_W(8), .BASE_ADDR(0), .DEPTH(256),
                   .DRAIN_CYCLES(1), .SKIP_ZERO(1)) u_dut_c (
      .clk(clk), .reset_n(reset_n), .instr_i(instr_c),
      .mem_rd_en_o(rd_en_c), .mem_addr_o(addr_c), .mem_rd_data_i(rdata_c),
      .out_valid_o(valid_c), .out_ready_i(ready), .out_addr_o(oaddr_c),
      .out_data_o(odata_c), .busy_o(busy_c), .done_o(done_c), .word_count_o(cnt_c));

   // Synchronous-read memories; garbage on non-read cycles exposes late sampling
   always @(posedge clk) begin
      rdata_a <= rd_en_a ? mem_a[addr_a[2:0]] : 16'hDEAD;
      rdata_b <= rd_en_b ? mem_b[addr_b[1:0]] : 16'hDEAD;
      rdata_c <= rd_en_c ? mem_c[addr_c]      : 16'hDEAD;
   end

   // Monitor view of whichever instance is under test
   int          sel;
   logic        m_rd_en, m_valid, m_busy, m_done;
   logic [31:0] m_addr, m_oaddr, m_odata, m_cnt;
   always_comb begin
      m_rd_en = rd_en_c; m_valid = valid_c; m_busy = busy_c; m_done = done_c;
      m_addr  = {24'h0, addr_c}; m_oaddr = {24'h0, oaddr_c};
      m_odata = {16'h0, odata_c}; m_cnt = {23'h0, cnt_c};
      case (sel)
         0: begin
            m_rd_en = rd_en_a; m_valid = valid_a; m_busy = busy_a; m_done = done_a;
            m_addr  = {16'h0, addr_a}; m_oaddr = {16'h0, oaddr_a};
            m_odata = {16'h0, odata_a}; m_cnt = {15'h0, cnt_a};
         end
         1: begin
            m_rd_en = rd_en_b; m_valid = valid_b; m_busy = busy_b; m_done = done_b;
            m_addr  = {16'h0, addr_b}; m_oaddr = {16'h0, oaddr_b};
            m_odata = {16'h0, odata_b}; m_cnt = {15'h0, cnt_b};
         end
         default: ;
      endcase
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
   endtask

   // Present a halt code for one cycle to the selected instance
   task automatic halt(input int s, input logic [15:0] code);
      sel = s;
      case (s)
         0: instr_a = code;
         1: instr_b = code;
         default: instr_c = code;
      endcase
      tick();
      instr_a = 16'h0000; instr_b = 16'h0000; instr_c = 16'h0000;
   endtask

   // Scan results collected by run_dump
   int unsigned q_addr[$];
   int unsigned q_data[$];
   int          done_cyc, first_rd_cyc;
   logic [31:0] first_rd_addr;
   logic        busy_ok, stable_ok, rd_seen;

   // Follow a dump from the cycle after the halt edge until done or budget expiry,
   // holding ready low for stall_n cycles at the start of every emitted word.
   task automatic run_dump(input int stall_n, input int budget);
      int cyc;
      int stall;
      logic [31:0] hold_a, hold_d;
      q_addr.delete(); q_data.delete();
      busy_ok = 1'b1; stable_ok = 1'b1; rd_seen = 1'b0;
      first_rd_cyc = -1; first_rd_addr = 32'hFFFF_FFFF;
      hold_a = 32'h0; hold_d = 32'h0;
      cyc = 0; stall = 0;
      while (!m_done && cyc <= budget) begin
         if (!m_busy) busy_ok = 1'b0;
         if (m_rd_en && !rd_seen) begin
            rd_seen = 1'b1; first_rd_cyc = cyc; first_rd_addr = m_addr;
         end
         if (m_valid) begin
            if (stall == 0) begin
               hold_a = m_oaddr; hold_d = m_odata;
            end else if (m_oaddr !== hold_a || m_odata !== hold_d) begin
               stable_ok = 1'b0;
            end
            if (stall < stall_n) begin
               ready = 1'b0; stall++;
            end else begin
               ready = 1'b1; stall = 0;
               q_addr.push_back(m_oaddr); q_data.push_back(m_odata);
            end
         end
         tick();
         cyc++;
      end
      done_cyc = cyc;
   endtask

   // Compare collected words against an expected list
   task automatic check_words(input string tag, input int unsigned ea[$], input int unsigned ed[$]);
      check_val({tag, "_nwords"}, q_addr.size(), ea.size());
      for (int i = 0; i < ea.size(); i++) begin
         check_val({tag, "_addr"}, (i < q_addr.size()) ? q_addr[i] : 32'hFFFF_FFFF, ea[i]);
         check_val({tag, "_data"}, (i < q_data.size()) ? q_data[i] : 32'hFFFF_FFFF, ed[i]);
      end
   endtask

   logic [15:0] nh_codes [0:2];
   logic        saw_rd, saw_busy;

   initial begin
      reset_n = 1'b0; ready = 1'b1; sel = 0;
      instr_a = 16'h0000; instr_b = 16'h0000; instr_c = 16'h0000;
      mem_a[0] = 16'h0000; mem_a[1] = 16'h0005; mem_a[2] = 16'h0000; mem_a[3] = 16'h0000;
      mem_a[4] = 16'hBEEF; mem_a[5] = 16'h0000; mem_a[6] = 16'h0000; mem_a[7] = 16'h0007;
      for (int i = 0; i < 4; i++) mem_b[i] = 16'h0000;
      for (int i = 0; i < 256; i++) mem_c[i] = 16'h0000;
      mem_c[255] = 16'h0001;
      nh_codes[0] = 16'hE001; nh_codes[1] = 16'h0000; nh_codes[2] = 16'hF7FF;

      // Reset state
      repeat (3) tick();
      check_val("rst_rd_en", {31'h0, rd_en_a}, 32'h0);
      check_val("rst_valid", {31'h0, valid_a}, 32'h0);
      check_val("rst_busy",  {31'h0, busy_a},  32'h0);
      check_val("rst_done",  {31'h0, done_a},  32'h0);
      check_val("rst_count", {15'h0, cnt_a},   32'h0);
      reset_n = 1'b1;
      tick();

      // Non-halt instructions never start a scan
      saw_rd = 1'b0; saw_busy = 1'b0;
      for (int i = 0; i < 50; i++) begin
         instr_a = nh_codes[i % 3];
         tick();
         if (rd_en_a) saw_rd = 1'b1;
         if (busy_a)  saw_busy = 1'b1;
      end
      instr_a = 16'h0000;
      check_val("nohalt_rd_en", {31'h0, saw_rd},   32'h0);
      check_val("nohalt_busy",  {31'h0, saw_busy}, 32'h0);

      // Basic dump with ready held high
      halt(0, 16'hE000);
      check_val("basic_busy_t1", {31'h0, busy_a}, 32'h1);
      run_dump(0, 100);
      check_val("basic_first_rd", first_rd_cyc, 32'd2);
      check_val("basic_first_addr", first_rd_addr, 32'h0);
      check_val("basic_done_cyc", done_cyc, 32'd21);
      check_words("basic", '{1, 4, 7}, '{16'h0005, 16'hBEEF, 16'h0007});
      check_val("basic_count", {15'h0, cnt_a}, 32'd3);
      check_val("basic_done", {31'h0, done_a}, 32'h1);
      check_val("basic_busy_end", {31'h0, busy_a}, 32'h0);
      check_val("basic_busy_held", {31'h0, busy_ok}, 32'h1);

      // Backpressure: five stall cycles per word
      do_reset();
      halt(0, 16'hE000);
      run_dump(5, 200);
      check_val("bp_done_cyc", done_cyc, 32'd36);
      check_words("bp", '{1, 4, 7}, '{16'h0005, 16'hBEEF, 16'h0007});
      check_val("bp_stable", {31'h0, stable_ok}, 32'h1);
      check_val("bp_count", {15'h0, cnt_a}, 32'd3);
      ready = 1'b1;

      // Reset while a word is waiting for the consumer
      do_reset();
      ready = 1'b0;
      halt(0, 16'hE000);
      for (int i = 0; i < 50; i++) begin
         if (valid_a) break;
         tick();
      end
      check_val("mid_valid", {31'h0, valid_a}, 32'h1);
      check_val("mid_addr", {16'h0, oaddr_a}, 32'h1);
      #2 reset_n = 1'b0;
      #1;
      check_val("mid_rst_valid", {31'h0, valid_a}, 32'h0);
      check_val("mid_rst_addr",  {16'h0, oaddr_a}, 32'h0);
      check_val("mid_rst_data",  {16'h0, odata_a}, 32'h0);
      check_val("mid_rst_busy",  {31'h0, busy_a},  32'h0);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      ready = 1'b1;
      halt(0, 16'hE000);
      run_dump(0, 100);
      check_val("restart_first_addr", first_rd_addr, 32'h0);
      check_val("restart_done_cyc", done_cyc, 32'd21);
      check_words("restart", '{1, 4, 7}, '{16'h0005, 16'hBEEF, 16'h0007});
      check_val("restart_count", {15'h0, cnt_a}, 32'd3);

      // Alternate halt code, keep zeros, no drain
      halt(1, 16'hE7FF);
      run_dump(0, 100);
      check_val("keep_first_rd", first_rd_cyc, 32'd0);
      check_val("keep_done_cyc", done_cyc, 32'd12);
      check_words("keep", '{0, 1, 2, 3}, '{0, 0, 0, 0});
      check_val("keep_count", {15'h0, cnt_b}, 32'd4);
      check_val("keep_done", {31'h0, done_b}, 32'h1);

      // Full address range: only the last word is nonzero, no wrap
      halt(2, 16'hE000);
      run_dump(0, 1000);
      check_val("full_first_rd", first_rd_cyc, 32'd1);
      check_val("full_done_cyc", done_cyc, 32'd514);
      check_words("full", '{255}, '{1});
      check_val("full_count", {23'h0, cnt_c}, 32'd1);
      check_val("full_done", {31'h0, done_c}, 32'h1);

      // A later halt after done does not restart
      halt(2, 16'hE000);
      saw_rd = 1'b0; saw_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rd_en_c) saw_rd = 1'b1;
         if (busy_c)  saw_busy = 1'b1;
         tick();
      end
      check_val("rehalt_rd_en", {31'h0, saw_rd}, 32'h0);
      check_val("rehalt_busy", {31'h0, saw_busy}, 32'h0);
      check_val("rehalt_done", {31'h0, done_c}, 32'h1);
      check_val("rehalt_count", {23'h0, cnt_c}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
